// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, funct
// codes, ALU control/op codes, mux selects and the FSM state encoding.
package multicycle_controller_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALUControl codes seen by the ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;

  // ALUOp: how the ALU decoder picks ALUControl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSrc selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states; encodings 12..15 are unreachable and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALUWB_R = 4'd7,
    S_EXEC_I  = 4'd8,
    S_ALUWB_I = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  // Logical immediates are zero-extended; arithmetic ones are sign-extended
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // Immediate ALU instructions handled by EXEC_I/ALUWB_I
  function automatic logic is_itype_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct (R-type) or opcode (I-type) onto the
// ALU control code. Also flags supported funct values and the sll shift case.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       shift_op,
  output logic       funct_valid
);

  logic [2:0] funct_alu;
  logic [2:0] itype_alu;

  // R-type funct table; funct_valid is independent of alu_op so DECODE can use it
  always_comb begin
    funct_alu   = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      FN_SLL:  funct_alu = ALU_SLL;
      default: funct_valid = 1'b0;
    endcase
  end

  // Immediate-instruction table keyed by opcode
  always_comb begin
    itype_alu = ALU_ADD;
    case (op)
      OP_ADDI: itype_alu = ALU_ADD;
      OP_ANDI: itype_alu = ALU_AND;
      OP_ORI:  itype_alu = ALU_OR;
      OP_SLTI: itype_alu = ALU_SLT;
      default: itype_alu = ALU_ADD;
    endcase
  end

  // Final ALU control selection
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_alu;
      ALUOP_ITYPE: alu_control = itype_alu;
      default:     alu_control = ALU_ADD;
    endcase
  end

  // The top gates this with the R-type states; it only identifies the sll funct
  assign shift_op = (funct == FN_SLL);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM. Moore outputs decoded from the state
// register; only PCEn looks at the live Zero flag (for beq).
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtZero,
  output logic       ShiftOp,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  state_e     state_reg;
  state_e     state_next;
  state_e     out_state;
  logic       decode_illegal;
  logic       pc_write;
  logic       branch;
  logic       shift_en;
  logic [1:0] alu_op;
  logic [2:0] dec_alu_control;
  logic       dec_shift_op;
  logic       dec_funct_valid;

  multicycle_controller_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .op          (op),
    .funct       (funct),
    .alu_control (dec_alu_control),
    .shift_op    (dec_shift_op),
    .funct_valid (dec_funct_valid)
  );

  // State register; reset parks the FSM in FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; DECODE sends unsupported op/funct straight back to FETCH
  always_comb begin
    state_next     = S_FETCH;
    decode_illegal = 1'b0;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) begin
          state_next = S_MEMADR;
        end else if (op == OP_RTYPE) begin
          if (dec_funct_valid) begin
            state_next = S_EXEC_R;
          end else begin
            decode_illegal = 1'b1;
          end
        end else if (is_itype_op(op)) begin
          state_next = S_EXEC_I;
        end else if (op == OP_BEQ) begin
          state_next = S_BRANCH;
        end else if (op == OP_J) begin
          state_next = S_JUMP;
        end else begin
          decode_illegal = 1'b1;
        end
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_next = S_MEMRD;
        end else if (op == OP_SW) begin
          state_next = S_MEMWR;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEMRD:  state_next = S_MEMWB;
      S_EXEC_R: state_next = S_ALUWB_R;
      S_EXEC_I: state_next = S_ALUWB_I;
      default:  state_next = S_FETCH;
    endcase
  end

  // While reset is high the non-write outputs show their FETCH values
  assign out_state = reset ? S_FETCH : state_reg;

  // Output decode from state; write strobes are masked during reset
  always_comb begin
    pc_write = 1'b0;
    branch   = 1'b0;
    shift_en = 1'b0;
    alu_op   = ALUOP_ADD;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    ExtZero  = 1'b0;
    PCSrc    = PCSRC_ALU;
    case (out_state)
      S_FETCH: begin
        IRWrite  = 1'b1;
        pc_write = 1'b1;
        ALUSrcB  = SRCB_FOUR;
      end
      S_DECODE: begin
        // Branch target is computed speculatively and parked in ALUOut
        ALUSrcB = SRCB_IMM_SH2;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA  = 1'b1;
        alu_op   = ALUOP_FUNCT;
        shift_en = 1'b1;
      end
      S_ALUWB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        shift_en = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_ITYPE;
        ExtZero = is_zext_op(op);
      end
      S_ALUWB_I: begin
        // ALU fields held so the immediate path stays stable through writeback
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        alu_op   = ALUOP_ITYPE;
        ExtZero  = is_zext_op(op);
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      S_JUMP: begin
        PCSrc    = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
    ALUControl = dec_alu_control;
    ShiftOp    = shift_en & dec_shift_op;
    PCEn       = pc_write | (branch & Zero);
    Illegal    = decode_illegal;
    if (reset) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction runs
// followed by random instructions, Zero values and mid-instruction resets,
// each cycle compared against a per-instruction-class reference model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       Zero = 1'b0;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtZero, ShiftOp;
  logic [1:0] PCSrc;
  logic [2:0] ALUControl;
  logic       Illegal;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic       shift_op;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       illegal;
  } outs_t;

  outs_t obs;
  int vectors = 0;
  int miscompares = 0;

  localparam int CL_LW = 0, CL_SW = 1, CL_R = 2, CL_I = 3, CL_BEQ = 4, CL_J = 5, CL_ILL = 6;

  logic [5:0] leg_op [15] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h04, 6'h02, 6'h04};
  logic [5:0] leg_fn [15] = '{6'h11, 6'h05, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00,
                              6'h3F, 6'h20, 6'h00, 6'h22, 6'h2A, 6'h01, 6'h00};

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .Zero       (Zero),
    .PCEn       (PCEn),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ExtZero    (ExtZero),
    .ShiftOp    (ShiftOp),
    .PCSrc      (PCSrc),
    .ALUControl (ALUControl),
    .Illegal    (Illegal)
  );

  assign obs = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ExtZero, ShiftOp, PCSrc, ALUControl, Illegal};

  always #5 clk = ~clk;

  // Instruction class from the supported-instruction list
  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h23: return CL_LW;
      6'h2B: return CL_SW;
      6'h00: return (f inside {6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? CL_R : CL_ILL;
      6'h08, 6'h0C, 6'h0D, 6'h0A: return CL_I;
      6'h04: return CL_BEQ;
      6'h02: return CL_J;
      default: return CL_ILL;
    endcase
  endfunction

  // Cycles per instruction by class
  function automatic int cpi(input int cl);
    case (cl)
      CL_LW: return 5;
      CL_BEQ, CL_J: return 3;
      CL_ILL: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'h20: return 3'b000;
      6'h22: return 3'b001;
      6'h24: return 3'b010;
      6'h25: return 3'b011;
      6'h2A: return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] o);
    case (o)
      6'h0C: return 3'b010;
      6'h0D: return 3'b011;
      6'h0A: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // Outputs while reset is held: FETCH values with all strobes off
  function automatic outs_t reset_values();
    outs_t e = '0;
    e.alu_src_b = 2'b01;
    return e;
  endfunction

  // Expected outputs for cycle k (0 = FETCH) of instruction (o,f)
  function automatic outs_t expect_at(input logic [5:0] o, input logic [5:0] f,
                                      input int k, input logic z);
    outs_t e = '0;
    int cl = classify(o, f);
    if (k == 0) begin
      e.ir_write = 1'b1; e.pc_en = 1'b1; e.alu_src_b = 2'b01;
      return e;
    end
    if (k == 1) begin
      e.alu_src_b = 2'b11; e.illegal = (cl == CL_ILL);
      return e;
    end
    case (cl)
      CL_LW, CL_SW: begin
        if (k == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
        else if (k == 3) begin e.iord = 1'b1; e.mem_write = (cl == CL_SW); end
        else begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
      end
      CL_R: begin
        e.shift_op = (f == 6'h00);
        if (k == 2) begin e.alu_src_a = 1'b1; e.alu_control = r_alu(f); end
        else begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      end
      CL_I: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_control = i_alu(o);
        e.ext_zero = (o == 6'h0C) || (o == 6'h0D);
        e.reg_write = (k == 3);
      end
      CL_BEQ: begin
        e.alu_src_a = 1'b1; e.alu_control = 3'b001; e.pc_src = 2'b01; e.pc_en = z;
      end
      CL_J: begin
        e.pc_src = 2'b10; e.pc_en = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input outs_t e, input string tag);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // Runs one instruction from its FETCH cycle; entered and left at posedge+1 of a FETCH cycle.
  // zmode <0 randomizes Zero each cycle; rst_k >=0 asserts reset in that cycle.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input int zmode, input int rst_k);
    int n;
    logic z;
    op = o;
    funct = f;
    n = cpi(classify(o, f));
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      Zero = z;
      if (k == rst_k) begin
        reset = 1'b1;
        #1;
        check(reset_values(), $sformatf("%s reset@c%0d", name, k + 1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      #1;
      check(expect_at(o, f, k, z), $sformatf("%s op=%02h fn=%02h c%0d", name, o, f, k + 1));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, rk, n;
    logic [5:0] o, f;
    // Two reset cycles, then the first active FETCH
    @(posedge clk); #2; check(reset_values(), "reset c1");
    @(posedge clk); #2; check(reset_values(), "reset c2");
    @(posedge clk); #1; reset = 1'b0;

    run_instr("lw",      6'h23, 6'h00, -1, -1);
    run_instr("sub",     6'h00, 6'h22, -1, -1);
    run_instr("beq_z1",  6'h04, 6'h00,  1, -1);
    run_instr("beq_z0",  6'h04, 6'h00,  0, -1);
    run_instr("sll",     6'h00, 6'h00, -1, -1);
    run_instr("ori",     6'h0D, 6'h00, -1, -1);
    run_instr("ill_op",  6'h3F, 6'h00, -1, -1);
    run_instr("ill_fn",  6'h00, 6'h27, -1, -1);
    run_instr("j",       6'h02, 6'h00, -1, -1);
    run_instr("sw_rst",  6'h2B, 6'h00, -1,  3);
    run_instr("sw",      6'h2B, 6'h00, -1, -1);

    for (int i = 0; i < 300; i++) begin
      idx = int'($urandom_range(0, 16));
      if (idx < 15) begin
        o = leg_op[idx];
        f = (o == 6'h00) ? leg_fn[idx] : 6'($urandom_range(0, 63));
      end else if (idx == 15) begin
        o = 6'($urandom_range(0, 63));
        f = 6'($urandom_range(0, 63));
      end else begin
        o = 6'h00;
        f = 6'($urandom_range(0, 63));
      end
      n = cpi(classify(o, f));
      rk = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_instr($sformatf("rnd%0d", i), o, f, -1, rk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
